// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: instruction field positions,
// default reset PC and the fetch-stage FSM encoding.
package mips_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    // Each buffered entry is {instruction word, address of that word + 4}.
    localparam int FIFO_W = 64;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO between instruction memory and decode. The head is a
// register of its own, so the decode-side outputs come straight from a flop.
module fetch_fifo
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [FIFO_W-1:0] din_i,
    output logic [FIFO_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [FIFO_W-1:0] head_q, head_d;
    logic [FIFO_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop, do_push;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        // A full queue can still take a word when the head leaves this cycle.
        do_push = push_i && ((count_q != 2'd2) || do_pop);

        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = din_i;
                    end else begin
                        head_d = din_i;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) head_d = din_i;
                    else                 tail_d = din_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, keeps at most one memory read in flight,
// buffers returned words and hands them to decode; redirects flush everything.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        InstrReady,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [5:0]  funct,
    output logic [31:0] PCPlus4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tag_q, tag_d;
    logic         accept, push, pop;
    logic [1:0]   count;
    logic [FIFO_W-1:0] head;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^RedirectPC[1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tag_d    = tag_q;
        imem_req = 1'b0;
        push     = 1'b0;
        accept   = 1'b0;

        case (state_q)
            // Issue is gated on the pre-pop count so the queue never overfills.
            FETCH: imem_req = !reset && (count < 2'd2);
            WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        accept = imem_req && imem_ready;
        if (accept) begin
            pc_d    = pc_q + 32'd4;
            tag_d   = pc_q + 32'd4;
            state_d = WAIT;
        end

        // A read still owed to us after a redirect must be swallowed in DRAIN.
        if (Redirect) begin
            push = 1'b0;
            pc_d = {RedirectPC[31:2], 2'b00};
            if (accept || ((state_q != FETCH) && !imem_rvalid))
                state_d = DRAIN;
            else
                state_d = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= {PC_RESET[31:2], 2'b00};
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
        end
    end

    assign pop = InstrValid && InstrReady && !Redirect;

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (Redirect),
        .din_i   ({imem_rdata, tag_q}),
        .head_o  (head),
        .count_o (count)
    );

    assign imem_addr  = pc_q;
    assign InstrValid = (count != 2'd0);
    assign Instr      = head[63:32];
    assign PCPlus4    = head[31:0];
    assign Opcode     = Instr[OPCODE_MSB:OPCODE_LSB];
    assign funct      = Instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a reference table for the zero-wait stream, directed
// corner sequences, and a randomized run against a queue-level model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        Redirect, InstrReady, InstrValid;
    logic [31:0] RedirectPC, Instr, PCPlus4;
    logic [5:0]  Opcode, funct;

    logic        imem_req2, InstrValid2;
    logic [31:0] imem_addr2, Instr2, PCPlus42;
    logic [5:0]  Opcode2, funct2;

    always #5 clk = ~clk;

    instr_fetch #(.PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .InstrReady(InstrReady),
        .InstrValid(InstrValid), .Instr(Instr), .Opcode(Opcode), .funct(funct),
        .PCPlus4(PCPlus4));

    instr_fetch #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .InstrReady(InstrReady),
        .InstrValid(InstrValid2), .Instr(Instr2), .Opcode(Opcode2), .funct(funct2),
        .PCPlus4(PCPlus42));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0022_1820;
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    // Reference model: words the DUT should be holding, plus one memory read slot.
    typedef struct { logic [31:0] instr; logic [31:0] pcp4; } ent_t;
    ent_t        q[$];
    bit          out_pend, out_live;
    int          out_wait, lat, pops;
    logic [31:0] out_addr, exp_fetch;

    task automatic sample();
        ent_t h;
        imem_rvalid = out_pend && (out_wait == 0);
        imem_rdata  = imem_rvalid ? word(out_addr) : $urandom;
        #1;
        chk("m_req", imem_req, (!out_pend && q.size() < 2));
        if (imem_req) chk("m_addr", imem_addr, exp_fetch);
        chk("m_valid", InstrValid, q.size() != 0);
        if (q.size() != 0) begin
            h = q[0];
            chk("m_instr", Instr, h.instr);
            chk("m_pcplus4", PCPlus4, h.pcp4);
            chk("m_opcode", Opcode, h.instr[31:26]);
            chk("m_funct", funct, h.instr[5:0]);
        end
    endtask

    task automatic advance();
        bit          acc, hs, rv, redir;
        logic [31:0] a, rpc;
        acc = imem_req && imem_ready;
        a = imem_addr;
        hs = InstrValid && InstrReady && !Redirect;
        rv = imem_rvalid;
        redir = Redirect;
        rpc = RedirectPC;
        @(posedge clk);
        if (redir) begin
            q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (hs && q.size() != 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (rv && out_live) q.push_back('{instr: word(out_addr), pcp4: out_addr + 32'd4});
        end
        if (rv) out_pend = 0;
        else if (out_pend && out_wait > 0) out_wait--;
        if (redir) out_live = 0;
        if (acc) begin
            out_pend = 1;
            out_addr = a;
            out_wait = lat - 1;
            out_live = !redir;
            if (!redir) exp_fetch = a + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic rst_dut(input bit check_state);
        reset = 1'b1;
        Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        if (check_state) begin
            chk("rst_req", imem_req, 1'b0);
            chk("rst_addr", imem_addr, 32'h0);
            chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
            chk("rst_valid", InstrValid, 1'b0);
            chk("rst_instr", Instr, 32'h0);
            chk("rst_pcplus4", PCPlus4, 32'h0);
        end
        q.delete();
        out_pend = 0; out_live = 0; out_wait = 0; exp_fetch = 32'h0;
        reset = 1'b0;
    endtask

    typedef struct {
        logic ready; logic iready;
        logic req; logic [31:0] addr; logic valid; logic [31:0] instr; logic [31:0] pcp4;
        logic [31:0] addr2;
    } vec_t;
    vec_t vecs[6];

    initial begin
        pops = 0;
        lat = 1;
        // Zero-wait stream from reset; dut2 starts at the top of the address space.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0022_1820, 32'h4, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0, 32'h4};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, word(32'h4), 32'h8, 32'h4};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'hC, 1'b0, 32'h0, 32'h0, 32'h8};

        rst_dut(1'b1);
        for (int i = 0; i < 6; i++) begin
            imem_ready = vecs[i].ready;
            InstrReady = vecs[i].iready;
            sample();
            chk("tbl_req", imem_req, vecs[i].req);
            chk("tbl_addr", imem_addr, vecs[i].addr);
            chk("tbl_valid", InstrValid, vecs[i].valid);
            if (vecs[i].valid) begin
                chk("tbl_instr", Instr, vecs[i].instr);
                chk("tbl_pcplus4", PCPlus4, vecs[i].pcp4);
            end
            chk("tbl_addr2", imem_addr2, vecs[i].addr2);
            if (i == 2) begin
                chk("tbl_opcode", Opcode, 32'h0);
                chk("tbl_funct", funct, 32'h20);
                chk("wrap_valid2", InstrValid2, 1'b1);
                chk("wrap_pcplus4", PCPlus42, 32'h0);
            end
            advance();
        end

        // Backpressure: two words buffered, then drained in order.
        rst_dut(1'b0);
        imem_ready = 1'b1; InstrReady = 1'b0; lat = 1;
        for (int c = 0; c < 7; c++) begin
            sample();
            if (c >= 4) begin
                chk("bp_req", imem_req, 1'b0);
                chk("bp_head", Instr, 32'h0022_1820);
                chk("bp_pcplus4", PCPlus4, 32'h4);
            end
            advance();
        end
        InstrReady = 1'b1;
        sample(); advance();
        sample();
        chk("bp_resume_req", imem_req, 1'b1);
        chk("bp_resume_addr", imem_addr, 32'h8);
        chk("bp_second", Instr, word(32'h4));
        chk("bp_second_pc4", PCPlus4, 32'h8);
        advance();

        // Redirect while a read is outstanding: returning word is dropped.
        rst_dut(1'b0);
        imem_ready = 1'b1; InstrReady = 1'b1; lat = 2;
        sample(); advance();
        Redirect = 1'b1; RedirectPC = 32'h0000_0043;
        sample(); advance();
        Redirect = 1'b0;
        sample();
        chk("drain_req", imem_req, 1'b0);
        advance();
        sample();
        chk("redir_req", imem_req, 1'b1);
        chk("redir_addr", imem_addr, 32'h40);
        advance();
        for (int k = 0; k < 10 && !InstrValid; k++) begin
            sample();
            if (!InstrValid) advance();
        end
        chk("redir_valid", InstrValid, 1'b1);
        chk("redir_pcplus4", PCPlus4, 32'h44);
        chk("redir_instr", Instr, word(32'h40));
        advance();

        // Redirect coinciding with rvalid while one word is buffered.
        rst_dut(1'b0);
        imem_ready = 1'b1; InstrReady = 1'b0; lat = 1;
        repeat (3) begin sample(); advance(); end
        Redirect = 1'b1; RedirectPC = 32'h0000_0100;
        sample();
        chk("rv_redir_valid_before", InstrValid, 1'b1);
        advance();
        Redirect = 1'b0;
        sample();
        chk("rv_redir_valid", InstrValid, 1'b0);
        chk("rv_redir_req", imem_req, 1'b1);
        chk("rv_redir_addr", imem_addr, 32'h100);
        advance();

        // Memory stall holds the address; then asynchronous reset mid-WAIT.
        rst_dut(1'b0);
        imem_ready = 1'b1; InstrReady = 1'b0; lat = 1;
        repeat (2) begin sample(); advance(); end
        imem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, 32'h4);
            advance();
        end
        imem_ready = 1'b1; lat = 3;
        sample(); advance();
        sample();
        chk("pre_rst_valid", InstrValid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", InstrValid, 1'b0);
        chk("arst_instr", Instr, 32'h0);
        chk("arst_pcplus4", PCPlus4, 32'h0);
        chk("arst_opcode", Opcode, 32'h0);
        chk("arst_funct", funct, 32'h0);

        // Randomized traffic against the queue model.
        rst_dut(1'b0);
        pops = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_ready = ($urandom % 4) != 0;
            InstrReady = ($urandom % 3) != 0;
            lat = 1 + ($urandom % 3);
            Redirect = ($urandom % 20) == 0;
            RedirectPC = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            sample();
            advance();
        end
        Redirect = 1'b0;
        chk("rand_progress", pops > 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
